// File: rtl/nonce_report_queue.sv
// Purpose: queues golden nonces and launches them one word at a time to the 4-byte serial transmitter.
// Latency: a nonce strobed into an empty queue with an idle transmitter raises tx_send 2 cycles later.
// Backpressure: launches only while tx_busy is low; a full queue drops new nonces and counts the drops.
module nonce_report_queue #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [31:0]   golden_nonce,
  input  logic          nonce_valid,
  input  logic          new_work,
  input  logic          tx_busy,
  output logic          tx_send,
  output logic [31:0]   tx_word,
  output logic [AW:0]   count,
  output logic          overflow,
  output logic [7:0]    drop_count
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SEND = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [31:0]   last_nonce;
  logic          last_valid;
  logic [1:0]    state;

  logic full;
  logic launch;
  logic dup;
  logic push_try;
  logic push;
  logic drop_full;

  // Decide this cycle's launch, accept and drop; a launch frees a slot for a same-cycle push.
  always_comb begin
    full      = (count == FULL_CNT);
    launch    = (state == ST_IDLE) && (count != '0) && !tx_busy && !new_work;
    dup       = last_valid && (golden_nonce == last_nonce);
    push_try  = nonce_valid && !new_work && !dup;
    push      = push_try && (!full || launch);
    drop_full = push_try && full && !launch;
  end

  // Nonce storage; no reset needed since count gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= golden_nonce;
    end
  end

  // Pointers, occupancy, duplicate filter and drop accounting; new_work flushes but keeps drop_count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow   <= 1'b0;
      drop_count <= 8'd0;
      last_nonce <= 32'd0;
      last_valid <= 1'b0;
    end else if (new_work) begin
      rd_ptr     <= wr_ptr;
      count      <= '0;
      overflow   <= 1'b0;
      last_valid <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (launch) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, launch};
      // A full-queue drop still records the nonce so its repeats are not counted again.
      if (push || drop_full) begin
        last_nonce <= golden_nonce;
        last_valid <= 1'b1;
      end
      if (drop_full) begin
        overflow <= 1'b1;
        if (drop_count != 8'hFF) begin
          drop_count <= drop_count + 8'd1;
        end
      end
    end
  end

  // Launch FSM: one-cycle send pulse, then hold until the transmitter reports idle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ST_IDLE;
      tx_send <= 1'b0;
      tx_word <= 32'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (launch) begin
            tx_send <= 1'b1;
            tx_word <= mem[rd_ptr];
            state   <= ST_SEND;
          end else begin
            tx_send <= 1'b0;
          end
        end
        ST_SEND: begin
          tx_send <= 1'b0;
          state   <= ST_HOLD;
        end
        ST_HOLD: begin
          tx_send <= 1'b0;
          if (!tx_busy) begin
            state <= ST_IDLE;
          end
        end
        default: begin
          tx_send <= 1'b0;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nonce_report_queue.sv
// Bench for nonce_report_queue: transmitter model, queue-level reference model,
// per-cycle comparison, and directed scenarios with literal expectations.
module tb_nonce_report_queue;

  localparam int DEPTH    = 8;
  localparam int AW       = 3;
  localparam int BUSY_CYC = 6;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [31:0]   golden_nonce = 32'd0;
  logic          nonce_valid = 1'b0;
  logic          new_work = 1'b0;
  logic          tx_busy;
  logic          tx_send;
  logic [31:0]   tx_word;
  logic [AW:0]   count;
  logic          overflow;
  logic [7:0]    drop_count;

  int ntests = 0;
  int nfail  = 0;

  nonce_report_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk          (clk),
    .reset        (reset),
    .golden_nonce (golden_nonce),
    .nonce_valid  (nonce_valid),
    .new_work     (new_work),
    .tx_busy      (tx_busy),
    .tx_send      (tx_send),
    .tx_word      (tx_word),
    .count        (count),
    .overflow     (overflow),
    .drop_count   (drop_count)
  );

  always #5 clk = ~clk;

  // Transmitter: busy for BUSY_CYC cycles after sampling send; stall forces busy.
  int   tcnt = 0;
  logic stall = 1'b0;
  always @(posedge clk) begin
    if (tx_send) tcnt <= BUSY_CYC;
    else if (tcnt != 0) tcnt <= tcnt - 1;
  end
  assign tx_busy = (tcnt != 0) || stall;

  // Reference model: a plain queue plus "ready to launch" bookkeeping.
  logic [31:0] mq[$];
  logic        m_send  = 1'b0;
  logic [31:0] m_word  = 32'd0;
  logic        m_ovf   = 1'b0;
  int          m_drop  = 0;
  logic        m_lv    = 1'b0;
  logic [31:0] m_ln    = 32'd0;
  logic        m_armed = 1'b1;
  logic        m_go;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mq.delete();
      m_send = 1'b0; m_word = 32'd0; m_ovf = 1'b0; m_drop = 0;
      m_lv = 1'b0; m_ln = 32'd0; m_armed = 1'b1;
    end else begin
      m_go = m_armed && (mq.size() != 0) && !tx_busy && !new_work;
      // After a send, the launcher is ready again once a post-send cycle shows the transmitter idle.
      if (m_go) m_armed = 1'b0;
      else if (!m_send && !tx_busy) m_armed = 1'b1;
      m_send = m_go;
      if (m_go) m_word = mq.pop_front();
      if (new_work) begin
        mq.delete(); m_ovf = 1'b0; m_lv = 1'b0;
      end else if (nonce_valid && !(m_lv && golden_nonce == m_ln)) begin
        m_ln = golden_nonce; m_lv = 1'b1;
        if (mq.size() < DEPTH) mq.push_back(golden_nonce);
        else begin
          m_ovf = 1'b1;
          if (m_drop != 255) m_drop = m_drop + 1;
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model and a log of launched words.
  logic [31:0] sent[$];
  always @(negedge clk) begin
    check("cyc_tx_send", {31'd0, tx_send}, {31'd0, m_send});
    check("cyc_tx_word", tx_word, m_word);
    check("cyc_count", {28'd0, count}, mq.size());
    check("cyc_overflow", {31'd0, overflow}, {31'd0, m_ovf});
    check("cyc_drop_count", {24'd0, drop_count}, m_drop);
    if (tx_send) sent.push_back(tx_word);
  end

  task automatic strobe(input logic [31:0] v);
    nonce_valid = 1'b1;
    golden_nonce = v;
    @(negedge clk);
    nonce_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_send(input string name);
    int n;
    n = 0;
    while (!tx_send && n < 100) begin
      @(negedge clk);
      n++;
    end
    ntests++;
    if (!tx_send) begin
      nfail++;
      $display("FAIL %s: tx_send never rose, got 0 expected 1", name);
    end
  endtask

  int base;

  initial begin
    // Reset state
    idle(3);
    check("rst_tx_send", {31'd0, tx_send}, 32'd0);
    check("rst_tx_word", tx_word, 32'd0);
    check("rst_count", {28'd0, count}, 32'd0);
    check("rst_overflow", {31'd0, overflow}, 32'd0);
    check("rst_drop_count", {24'd0, drop_count}, 32'd0);
    reset = 1'b1;
    idle(3);

    // 1: single nonce, launched 2 cycles after the strobe
    strobe(32'hDEADBEEF);
    check("t1_count_1", {28'd0, count}, 32'd1);
    check("t1_no_send_yet", {31'd0, tx_send}, 32'd0);
    @(negedge clk);
    check("t1_send", {31'd0, tx_send}, 32'd1);
    check("t1_word", tx_word, 32'hDEADBEEF);
    check("t1_count_0", {28'd0, count}, 32'd0);
    @(negedge clk);
    check("t1_pulse_one_cycle", {31'd0, tx_send}, 32'd0);
    idle(15);

    // 3: same nonce strobed three times -> one report, no drops
    base = sent.size();
    strobe(32'h00001234);
    strobe(32'h00001234);
    strobe(32'h00001234);
    idle(25);
    check("t3_sends", sent.size() - base, 32'd1);
    check("t3_word", sent[sent.size() - 1], 32'h00001234);
    check("t3_drop_count", {24'd0, drop_count}, 32'd0);

    // 2: burst of 10 with stalled transmitter
    stall = 1'b1;
    base = sent.size();
    for (int i = 0; i < 10; i++) strobe(32'h100 + i);
    check("t2_count_peak", {28'd0, count}, 32'd8);
    check("t2_overflow", {31'd0, overflow}, 32'd1);
    check("t2_drop_count", {24'd0, drop_count}, 32'd2);
    stall = 1'b0;
    idle(120);
    check("t2_sends", sent.size() - base, 32'd8);
    for (int i = 0; i < 8; i++) check("t2_order", sent[base + i], 32'h100 + i);

    // 4: flush with a word in flight
    stall = 1'b1;
    for (int i = 0; i < 6; i++) strobe(32'h200 + i);
    stall = 1'b0;
    wait_send("t4_launch");
    check("t4_word_inflight", tx_word, 32'h200);
    check("t4_count_5", {28'd0, count}, 32'd5);
    check("t4_overflow_before", {31'd0, overflow}, 32'd1);
    new_work = 1'b1;
    @(negedge clk);
    new_work = 1'b0;
    check("t4_count_flushed", {28'd0, count}, 32'd0);
    check("t4_overflow_cleared", {31'd0, overflow}, 32'd0);
    check("t4_drop_kept", {24'd0, drop_count}, 32'd2);
    base = sent.size();
    idle(30);
    check("t4_no_more_sends", sent.size() - base, 32'd0);
    strobe(32'h205);
    idle(20);
    check("t4_resend_count", sent.size() - base, 32'd1);
    check("t4_resend_word", sent[sent.size() - 1], 32'h205);
    idle(10);

    // 5: full queue, push coincides with launch
    stall = 1'b1;
    for (int i = 0; i < 8; i++) strobe(32'h300 + i);
    check("t5_full", {28'd0, count}, 32'd8);
    base = sent.size();
    stall = 1'b0;
    nonce_valid = 1'b1;
    golden_nonce = 32'h308;
    @(negedge clk);
    nonce_valid = 1'b0;
    check("t5_send", {31'd0, tx_send}, 32'd1);
    check("t5_word", tx_word, 32'h300);
    check("t5_count_stays", {28'd0, count}, 32'd8);
    check("t5_no_drop", {24'd0, drop_count}, 32'd2);
    idle(120);
    check("t5_sends", sent.size() - base, 32'd9);
    check("t5_last", sent[sent.size() - 1], 32'h308);

    // 6: saturation, then reset during SEND
    stall = 1'b1;
    for (int i = 0; i < 308; i++) strobe(32'h1000 + i);
    check("t6_full", {28'd0, count}, 32'd8);
    check("t6_sat", {24'd0, drop_count}, 32'd255);
    check("t6_overflow", {31'd0, overflow}, 32'd1);
    stall = 1'b0;
    wait_send("t6_launch");
    #2 reset = 1'b0;
    #1;
    check("t6_rst_send", {31'd0, tx_send}, 32'd0);
    check("t6_rst_word", tx_word, 32'd0);
    check("t6_rst_count", {28'd0, count}, 32'd0);
    check("t6_rst_overflow", {31'd0, overflow}, 32'd0);
    check("t6_rst_drop", {24'd0, drop_count}, 32'd0);
    base = sent.size();
    @(negedge clk);
    reset = 1'b1;
    idle(2);
    strobe(32'hCAFE0001);
    idle(30);
    check("t6_post_sends", sent.size() - base, 32'd1);
    check("t6_post_word", sent[sent.size() - 1], 32'hCAFE0001);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
